reg_file: RTL and testbench
===========================

// Module: reg_file
//
// PURPOSE
//   Parametrised multi-register storage; successor to the single reg16 cell.
//   - DEPTH registers of WIDTH bits.
//   - One synchronous write port; two gated read ports (A, B).
//   - Optional hardwired-zero register 0 and optional same-cycle write bypass.
//   - Per-register pending scoreboard, so the CPU datapath can stall on
//     results that are not yet written back.
//
// PARAMETERS
//   WIDTH     16  data width of every register, >= 1
//   DEPTH     8   number of registers; power of two, >= 2; AW = $clog2(DEPTH)
//   ZERO_REG  0   1: register 0 reads as 0, ignores writes and claims
//   BYPASS    1   1: a read of the address being written returns d in the same cycle
//
// PORTS
//   clk         in   1      clock; all state updates on posedge
//   rst         in   1      synchronous reset, active-high
//   we          in   1      write enable
//   waddr       in   AW     write address
//   d           in   WIDTH  write data
//   claim       in   1      mark register claim_addr as pending (producer issued)
//   claim_addr  in   AW     register to mark pending
//   selA        in   1      read port A enable
//   addrA       in   AW     read port A address
//   a           out  WIDTH  read port A data
//   pendA       out  1      register addressed on port A is pending
//   selB        in   1      read port B enable
//   addrB       in   AW     read port B address
//   b           out  WIDTH  read port B data
//   pendB       out  1      register addressed on port B is pending
//
// BEHAVIOUR
//   Reset
//   - rst=1 at posedge: every register <= 0, every pending bit <= 0.
//   - rst has priority over we and claim in the same cycle.
//   - Outputs are combinational from state, so all reads return 0 after reset
//     and pendA = pendB = 0.
//
//   Write
//   - At posedge, if we && !rst: reg[waddr] <= d and pending[waddr] <= 0.
//   - One cycle of latency to the stored state.
//
//   Claim
//   - At posedge, if claim && !rst: pending[claim_addr] <= 1.
//   - claim and we to the same address in one cycle: data is written, and
//     pending ends up 1 (the new producer wins).
//
//   Zero register (ZERO_REG=1)
//   - Writes and claims to address 0 are ignored.
//   - Reads of address 0 return 0 with pend = 0.
//
//   Read (combinational, zero latency; ports fully independent)
//   - a = selA ? value(addrA) : 0; b likewise with selB/addrB.
//   - Ports A and B may read the same address simultaneously.
//   - value(x):
//       - BYPASS=1 and we && waddr==x (and not the zero register): d.
//       - Otherwise: reg[x].
//   - BYPASS=0: a written value becomes visible the cycle after the write edge.
//   - Disabled port (sel=0) drives 0, never Z or X.
//
//   Pending outputs
//   - pendA = selA && pending[addrA]
//             && !(BYPASS && we && waddr==addrA && !(claim && claim_addr==addrA)).
//   - pendB likewise.
//   - A bypassed writeback therefore releases a stall in the same cycle.
//
//   Mid-operation reset
//   - rst=1 clears all state regardless of in-flight claims.
//   - Any outstanding producer's later write is accepted normally as data
//     (pending stays 0).
//
// TESTING (WIDTH=16, DEPTH=8, ZERO_REG=1, BYPASS=1 unless noted)
//   1. Reset, then we=1 waddr=3 d=16'hF0F0. Next cycle selA=1 addrA=3
//      -> a=16'hF0F0. selA=0 -> a=16'h0000.
//   2. Bypass: same cycle we=1 waddr=5 d=16'h1234 with selB=1 addrB=5
//      -> b=16'h1234 before the edge. With BYPASS=0 -> b=old value (0)
//      until after the edge.
//   3. Zero register: we=1 waddr=0 d=16'hFFFF, plus claim=1 claim_addr=0.
//      Next cycle selA=1 addrA=0 -> a=0, pendA=0.
//   4. Scoreboard: claim addr 2. Next cycle selA=1 addrA=2 -> pendA=1.
//      Then we=1 waddr=2 d=16'hCCCC -> pendA=0 and a=16'hCCCC in the same
//      cycle; after the edge pendA stays 0.
//   5. Same-edge claim+write to addr 4 (d=16'hAAAA) -> after the edge
//      reg4=16'hAAAA and pendA(addrA=4)=1.
//   6. Fill regs 1..7 with distinct values and claim 6. Assert rst for one
//      cycle with we=1 waddr=1 d=16'h5555 -> all reads 0, all pend 0;
//      the write is dropped.

Source files
------------

// File: rtl/reg_file_if.sv
// Register-file access bus: one write port, one claim port, two gated read ports.
//   master : datapath side, drives write/claim/read requests, receives read data
//   slave  : reg_file side
interface reg_file_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] d;
   logic             claim;
   logic [AW-1:0]    claim_addr;
   logic             selA;
   logic [AW-1:0]    addrA;
   logic [WIDTH-1:0] a;
   logic             pendA;
   logic             selB;
   logic [AW-1:0]    addrB;
   logic [WIDTH-1:0] b;
   logic             pendB;

   modport master (
      output we, waddr, d, claim, claim_addr, selA, addrA, selB, addrB,
      input  a, pendA, b, pendB
   );

   modport slave (
      input  we, waddr, d, claim, claim_addr, selA, addrA, selB, addrB,
      output a, pendA, b, pendB
   );
endinterface

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register storage with a per-register pending scoreboard.
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset, clears data and pending bits
//   bus  : reg_file_if slave
//          we/waddr/d          synchronous write, clears pending of target
//          claim/claim_addr    marks target pending (wins over same-edge write)
//          selA/addrA -> a/pendA, selB/addrB -> b/pendB
//                              combinational reads, 0 when port disabled
// ZERO_REG=1 hardwires register 0 to zero and never pending.
// BYPASS=1 forwards the write data to a read of the same address in the same cycle.
module reg_file #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 8,
   parameter bit          ZERO_REG = 1'b0,
   parameter bit          BYPASS   = 1'b1
) (
   input logic        clk,
   input logic        rst,
   reg_file_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pending;

   logic             wr_ok;
   logic             claim_ok;
   logic             zero_a;
   logic             zero_b;
   logic             hit_a;
   logic             hit_b;
   logic             release_a;
   logic             release_b;
   logic [WIDTH-1:0] a_c;
   logic [WIDTH-1:0] b_c;
   logic             pend_a_c;
   logic             pend_b_c;

   // Writes and claims aimed at a hardwired zero register are dropped.
   assign wr_ok    = bus.we    && !(ZERO_REG && (bus.waddr      == AW'(0)));
   assign claim_ok = bus.claim && !(ZERO_REG && (bus.claim_addr == AW'(0)));

   // Storage and scoreboard; claim is applied after write so a same-edge claim wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         pending <= '0;
      end else begin
         if (wr_ok) begin
            regs[bus.waddr]    <= bus.d;
            pending[bus.waddr] <= 1'b0;
         end
         if (claim_ok) begin
            pending[bus.claim_addr] <= 1'b1;
         end
      end
   end

   // Bypass match per port; a same-cycle claim on the address keeps the stall asserted.
   assign zero_a    = ZERO_REG && (bus.addrA == AW'(0));
   assign zero_b    = ZERO_REG && (bus.addrB == AW'(0));
   assign hit_a     = BYPASS && wr_ok && (bus.waddr == bus.addrA);
   assign hit_b     = BYPASS && wr_ok && (bus.waddr == bus.addrB);
   assign release_a = BYPASS && bus.we && (bus.waddr == bus.addrA)
                      && !(bus.claim && (bus.claim_addr == bus.addrA));
   assign release_b = BYPASS && bus.we && (bus.waddr == bus.addrB)
                      && !(bus.claim && (bus.claim_addr == bus.addrB));

   // Read port A.
   always_comb begin
      a_c      = '0;
      pend_a_c = 1'b0;
      if (bus.selA && !zero_a) begin
         a_c      = hit_a ? bus.d : regs[bus.addrA];
         pend_a_c = pending[bus.addrA] && !release_a;
      end
   end

   // Read port B.
   always_comb begin
      b_c      = '0;
      pend_b_c = 1'b0;
      if (bus.selB && !zero_b) begin
         b_c      = hit_b ? bus.d : regs[bus.addrB];
         pend_b_c = pending[bus.addrB] && !release_b;
      end
   end

   assign bus.a     = a_c;
   assign bus.pendA = pend_a_c;
   assign bus.b     = b_c;
   assign bus.pendB = pend_b_c;
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: a bypassing DUT and a non-bypassing DUT share one stimulus
// stream; both use ZERO_REG=1, WIDTH=16, DEPTH=8.
module tb_reg_file;
   logic        clk;
   logic        rst;
   logic        we;
   logic [2:0]  waddr;
   logic [15:0] d;
   logic        claim;
   logic [2:0]  claim_addr;
   logic        selA;
   logic [2:0]  addrA;
   logic        selB;
   logic [2:0]  addrB;

   int total;
   int bad;

   // Reference state: plain arrays updated from the behavioural rules.
   logic [15:0] mreg  [8];
   logic        mpend [8];

   reg_file_if #(.WIDTH(16), .DEPTH(8)) ifa ();
   reg_file_if #(.WIDTH(16), .DEPTH(8)) ifn ();

   assign ifa.we = we;       assign ifn.we = we;
   assign ifa.waddr = waddr; assign ifn.waddr = waddr;
   assign ifa.d = d;         assign ifn.d = d;
   assign ifa.claim = claim; assign ifn.claim = claim;
   assign ifa.claim_addr = claim_addr; assign ifn.claim_addr = claim_addr;
   assign ifa.selA = selA;   assign ifn.selA = selA;
   assign ifa.addrA = addrA; assign ifn.addrA = addrA;
   assign ifa.selB = selB;   assign ifn.selB = selB;
   assign ifa.addrB = addrB; assign ifn.addrB = addrB;

   reg_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   reg_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
      .clk (clk),
      .rst (rst),
      .bus (ifn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  waddr;
      logic [15:0] d;
      logic        claim;
      logic [2:0]  caddr;
      logic        sela;
      logic [2:0]  addra;
      logic        selb;
      logic [2:0]  addrb;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        epa;
      logic        epb;
      logic [15:0] enb_b;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_val(input bit byp, input logic sel, input logic [2:0] ad);
      if (!sel || ad == 3'd0) return 16'h0000;
      if (byp && we && waddr == ad) return d;
      return mreg[ad];
   endfunction

   function automatic logic m_pend(input bit byp, input logic sel, input logic [2:0] ad);
      if (!sel || ad == 3'd0) return 1'b0;
      if (byp && we && waddr == ad && !(claim && claim_addr == ad)) return 1'b0;
      return mpend[ad];
   endfunction

   task automatic check_model(input string tag);
      chk({tag, " byp.a"},    ifa.a,          m_val(1'b1, selA, addrA));
      chk({tag, " byp.b"},    ifa.b,          m_val(1'b1, selB, addrB));
      chk({tag, " byp.pendA"}, 16'(ifa.pendA), 16'(m_pend(1'b1, selA, addrA)));
      chk({tag, " byp.pendB"}, 16'(ifa.pendB), 16'(m_pend(1'b1, selB, addrB)));
      chk({tag, " nb.a"},     ifn.a,          m_val(1'b0, selA, addrA));
      chk({tag, " nb.b"},     ifn.b,          m_val(1'b0, selB, addrB));
      chk({tag, " nb.pendA"},  16'(ifn.pendA), 16'(m_pend(1'b0, selA, addrA)));
      chk({tag, " nb.pendB"},  16'(ifn.pendB), 16'(m_pend(1'b0, selB, addrB)));
   endtask

   // Advance one clock, applying the current inputs to the reference model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            mreg[i]  = 16'h0000;
            mpend[i] = 1'b0;
         end
      end else begin
         if (we && waddr != 3'd0) begin
            mreg[waddr]  = d;
            mpend[waddr] = 1'b0;
         end
         if (claim && claim_addr != 3'd0) mpend[claim_addr] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; we = 1'b0; waddr = 3'd0; d = 16'h0000;
      claim = 1'b0; claim_addr = 3'd0;
      selA = 1'b0; addrA = 3'd0; selB = 1'b0; addrB = 3'd0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      for (int i = 0; i < 8; i++) begin
         mreg[i]  = 16'hxxxx;
         mpend[i] = 1'bx;
      end

      // Directed vectors: {we,waddr,d,claim,caddr,selA,addrA,selB,addrB | a,b,pendA,pendB,nb.b}
      vt[0]  = '{1'b1, 3'd3, 16'hF0F0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 16'hF0F0, 16'h0000, 1'b0, 1'b0, 16'h0000};
      vt[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 3'd3, 16'hF0F0, 16'hF0F0, 1'b0, 1'b0, 16'hF0F0};
      vt[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd3, 16'h0000, 16'hF0F0, 1'b0, 1'b0, 16'hF0F0};
      vt[3]  = '{1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 3'd5, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000};
      vt[4]  = '{1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd5, 16'h0000, 16'h1234, 1'b0, 1'b0, 16'h1234};
      vt[5]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
      vt[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 3'd2, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000};
      vt[7]  = '{1'b1, 3'd2, 16'hCCCC, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 3'd2, 16'hCCCC, 16'hCCCC, 1'b0, 1'b0, 16'h0000};
      vt[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0, 3'd0, 16'hCCCC, 16'h0000, 1'b0, 1'b0, 16'h0000};
      vt[9]  = '{1'b1, 3'd4, 16'hAAAA, 1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd4, 16'hAAAA, 16'hAAAA, 1'b0, 1'b0, 16'h0000};
      vt[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd4, 16'hAAAA, 16'hAAAA, 1'b1, 1'b1, 16'hAAAA};

      // Reset state.
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         selA = 1'b1; addrA = 3'(i); selB = 1'b1; addrB = 3'(7 - i);
         #1;
         chk("reset a", ifa.a, 16'h0000);
         chk("reset pendB", 16'(ifa.pendB), 16'h0000);
         check_model("reset");
      end

      // Table-driven directed sequence.
      for (int i = 0; i < 11; i++) begin
         idle();
         we = vt[i].we; waddr = vt[i].waddr; d = vt[i].d;
         claim = vt[i].claim; claim_addr = vt[i].caddr;
         selA = vt[i].sela; addrA = vt[i].addra; selB = vt[i].selb; addrB = vt[i].addrb;
         #1;
         chk($sformatf("vec%0d a", i), ifa.a, vt[i].ea);
         chk($sformatf("vec%0d b", i), ifa.b, vt[i].eb);
         chk($sformatf("vec%0d pendA", i), 16'(ifa.pendA), 16'(vt[i].epa));
         chk($sformatf("vec%0d pendB", i), 16'(ifa.pendB), 16'(vt[i].epb));
         chk($sformatf("vec%0d nb.b", i), ifn.b, vt[i].enb_b);
         check_model($sformatf("vec%0d", i));
         tick();
      end

      // Fill regs 1..7, claim 6, then a reset cycle that collides with a write.
      for (int i = 1; i < 8; i++) begin
         idle();
         we = 1'b1; waddr = 3'(i); d = 16'h1000 + 16'(i) * 16'h0111;
         claim = (i == 7); claim_addr = 3'd6;
         selA = 1'b1; addrA = 3'(i - 1); selB = 1'b1; addrB = 3'(i);
         #1;
         check_model("fill");
         tick();
      end
      idle();
      selA = 1'b1; addrA = 3'd6;
      #1;
      chk("fill pend6", 16'(ifa.pendA), 16'h0001);
      chk("fill reg6", ifa.a, 16'h1666);
      idle();
      rst = 1'b1; we = 1'b1; waddr = 3'd1; d = 16'h5555;
      tick();
      idle();
      for (int i = 0; i < 8; i++) begin
         selA = 1'b1; addrA = 3'(i); selB = 1'b1; addrB = 3'(i);
         #1;
         chk($sformatf("midrst a%0d", i), ifa.a, 16'h0000);
         chk($sformatf("midrst pendA%0d", i), 16'(ifa.pendA), 16'h0000);
         chk($sformatf("midrst nb.b%0d", i), ifn.b, 16'h0000);
         check_model("midrst");
      end
      // Late write from the producer that held register 6.
      idle();
      we = 1'b1; waddr = 3'd6; d = 16'h7777;
      tick();
      idle();
      selA = 1'b1; addrA = 3'd6;
      #1;
      chk("late write a", ifa.a, 16'h7777);
      chk("late write pend", 16'(ifa.pendA), 16'h0000);
      chk("late write nb.a", ifn.a, 16'h7777);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 3000; n++) begin
         rst        = ($urandom_range(0, 63) == 0);
         we         = 1'($urandom_range(0, 1));
         waddr      = 3'($urandom_range(0, 7));
         d          = 16'($urandom);
         claim      = ($urandom_range(0, 2) == 0);
         claim_addr = 3'($urandom_range(0, 7));
         selA       = ($urandom_range(0, 3) != 0);
         addrA      = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
         selB       = ($urandom_range(0, 3) != 0);
         addrB      = ($urandom_range(0, 3) == 0) ? addrA : 3'($urandom_range(0, 7));
         #1;
         check_model("rand");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
